// File: rtl/sd_emmc_sdma_pkg.sv
// Shared definitions for the SDMA sequencer: FSM state encoding, the default
// smallest buffer boundary and the helper that turns a boundary code into a
// shift amount.
package sd_emmc_sdma_pkg;

    // Smallest SDMA buffer boundary is 4 KB (2^12); codes 0..7 give 4 KB..512 KB.
    localparam int BND_BASE_LOG2_DEF = 12;

    // Wide enough for any shift into a 32-bit (or up to 64-bit) address.
    localparam int SHIFT_W = 6;

    // FSM state encoding, kept as plain constants for legacy tool flows.
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_REQ       = 3'd1;
    localparam logic [2:0] ST_XFER      = 3'd2;
    localparam logic [2:0] ST_CHECK     = 3'd3;
    localparam logic [2:0] ST_WAIT_ADDR = 3'd4;
    localparam logic [2:0] ST_GAP       = 3'd5;

    typedef logic [2:0]         sdma_state_t;
    typedef logic [SHIFT_W-1:0] bnd_shift_t;

    // Boundary size is 2^(base + code) bytes, so the comparison shift is base + code.
    function automatic bnd_shift_t bnd_shift(input logic [2:0] code, input int base);
        return SHIFT_W'(base) + SHIFT_W'(code);
    endfunction

endpackage

// File: rtl/sd_emmc_sdma_engine_if.sv
// Memory-side handshake of the SDMA sequencer: one request per block
// (mem_req/mem_ack) and a completion pulse once the block has been moved.
interface sd_emmc_sdma_engine_if #(
    parameter int ADDR_W    = 32,
    parameter int BLKSIZE_W = 12
);
    logic                 mem_req;
    logic                 mem_ack;
    logic [ADDR_W-1:0]    mem_addr;
    logic [BLKSIZE_W-1:0] mem_len;
    logic                 blk_done;

    // The sequencer issues requests and consumes acknowledges / block-done pulses.
    modport master (
        output mem_req,
        output mem_addr,
        output mem_len,
        input  mem_ack,
        input  blk_done
    );

    // The memory mover accepts requests and reports block completion.
    modport slave (
        input  mem_req,
        input  mem_addr,
        input  mem_len,
        output mem_ack,
        output blk_done
    );
endinterface

// File: rtl/sd_emmc_sdma_bnd_chk.sv
// Combinational SDMA buffer-boundary crossing detector. A crossing is flagged
// when the old and new addresses fall in different boundary-sized windows, or
// when the address increment wrapped past the top of the address space.
module sd_emmc_sdma_bnd_chk
    import sd_emmc_sdma_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] old_addr,
    input  logic [ADDR_W-1:0] new_addr,
    input  bnd_shift_t        shift,
    output logic              crossing
);

    logic [ADDR_W-1:0] old_win;
    logic [ADDR_W-1:0] new_win;
    logic              wrapped;

    // Compare boundary window indices; a smaller new address means the add wrapped.
    always_comb begin
        old_win  = old_addr >> shift;
        new_win  = new_addr >> shift;
        wrapped  = (new_addr < old_addr);
        crossing = (old_win != new_win) || wrapped;
    end

endmodule

// File: rtl/sd_emmc_sdma_engine.sv
// SDMA sequencer for the eMMC host controller. Walks system memory one block
// at a time, issuing one memory request per block, and pauses with a dma_int
// pulse whenever a block crosses the programmed SDMA buffer boundary until
// host software supplies a new system address.
// Optional feature: define SD_EMMC_SDMA_BLK_GAP_EN to add block-gap stop
// (stop_at_gap / continue_req / gap_stopped and the GAP state).
module sd_emmc_sdma_engine
    import sd_emmc_sdma_pkg::*;
#(
    parameter int ADDR_W        = 32,
    parameter int BLKCNT_W      = 16,
    parameter int BLKSIZE_W     = 12,
    parameter int BND_BASE_LOG2 = BND_BASE_LOG2_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_W-1:0]     init_sys_addr,
    input  logic [2:0]            buf_boundary,
    input  logic [BLKSIZE_W-1:0]  block_size,
    input  logic [BLKCNT_W-1:0]   block_count,
    input  logic                  sys_addr_wr,
    input  logic [ADDR_W-1:0]     sys_addr_in,
`ifdef SD_EMMC_SDMA_BLK_GAP_EN
    input  logic                  stop_at_gap,
    input  logic                  continue_req,
    output logic                  gap_stopped,
`endif
    sd_emmc_sdma_engine_if.master mem,
    output logic                  busy,
    output logic                  dma_int,
    output logic                  xfer_complete,
    output logic [ADDR_W-1:0]     cur_sys_addr,
    output logic [BLKCNT_W-1:0]   blocks_left
);

    sdma_state_t          state_q,    state_d;
    logic [ADDR_W-1:0]    addr_q,     addr_d;
    logic [BLKSIZE_W-1:0] size_q,     size_d;
    logic [BLKCNT_W-1:0]  count_q,    count_d;
    bnd_shift_t           shift_q,    shift_d;
    logic                 cross_q,    cross_d;
    logic                 dma_int_q,  dma_int_d;
    logic                 xfer_cmp_q, xfer_cmp_d;

    logic [ADDR_W-1:0]    next_addr;
    logic                 cross_now;

    // Address of the following block; the add is modulo 2^ADDR_W by width.
    assign next_addr = addr_q + {{(ADDR_W-BLKSIZE_W){1'b0}}, size_q};

    // Crossing check between the current block start and the next one.
    sd_emmc_sdma_bnd_chk #(
        .ADDR_W (ADDR_W)
    ) u_bnd_chk (
        .old_addr (addr_q),
        .new_addr (next_addr),
        .shift    (shift_q),
        .crossing (cross_now)
    );

    // Next-state logic: abort overrides everything, then per-state sequencing.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        size_d     = size_q;
        count_d    = count_q;
        shift_d    = shift_q;
        cross_d    = cross_q;
        dma_int_d  = 1'b0;
        xfer_cmp_d = 1'b0;

        if (abort) begin
            // Cancel without any completion or boundary pulse.
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (block_count != '0) begin
                            addr_d  = init_sys_addr;
                            size_d  = block_size;
                            count_d = block_count;
                            shift_d = bnd_shift(buf_boundary, BND_BASE_LOG2);
                            cross_d = 1'b0;
                            state_d = ST_REQ;
                        end else begin
                            // Nothing to move: report completion straight away.
                            xfer_cmp_d = 1'b1;
                        end
                    end
                end

                ST_REQ: begin
                    if (mem.mem_ack) begin
                        state_d = ST_XFER;
                    end
                end

                ST_XFER: begin
                    if (mem.blk_done) begin
                        addr_d  = next_addr;
                        count_d = count_q - BLKCNT_W'(1);
                        cross_d = cross_now;
                        state_d = ST_CHECK;
                    end
                end

                ST_CHECK: begin
                    if (count_q == '0) begin
                        // A crossing on the last block needs no new address.
                        xfer_cmp_d = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        dma_int_d = cross_q;
`ifdef SD_EMMC_SDMA_BLK_GAP_EN
                        if (stop_at_gap) begin
                            // The crossing stays in cross_q and is honoured on continue.
                            state_d = ST_GAP;
                        end else
`endif
                        if (cross_q) begin
                            state_d = ST_WAIT_ADDR;
                        end else begin
                            state_d = ST_REQ;
                        end
                    end
                end

                ST_WAIT_ADDR: begin
                    if (sys_addr_wr) begin
                        addr_d  = sys_addr_in;
                        cross_d = 1'b0;
                        state_d = ST_REQ;
                    end
                end

`ifdef SD_EMMC_SDMA_BLK_GAP_EN
                ST_GAP: begin
                    if (continue_req) begin
                        state_d = cross_q ? ST_WAIT_ADDR : ST_REQ;
                    end
                end
`endif

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            size_q     <= '0;
            count_q    <= '0;
            shift_q    <= '0;
            cross_q    <= 1'b0;
            dma_int_q  <= 1'b0;
            xfer_cmp_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            size_q     <= size_d;
            count_q    <= count_d;
            shift_q    <= shift_d;
            cross_q    <= cross_d;
            dma_int_q  <= dma_int_d;
            xfer_cmp_q <= xfer_cmp_d;
        end
    end

    // Outputs decode directly from registered state.
    assign mem.mem_req    = (state_q == ST_REQ);
    assign mem.mem_addr   = addr_q;
    assign mem.mem_len    = size_q;
    assign busy           = (state_q != ST_IDLE);
    assign dma_int        = dma_int_q;
    assign xfer_complete  = xfer_cmp_q;
    assign cur_sys_addr   = addr_q;
    assign blocks_left    = count_q;
`ifdef SD_EMMC_SDMA_BLK_GAP_EN
    assign gap_stopped    = (state_q == ST_GAP);
`endif

endmodule

// File: doc/sd_emmc_sdma_engine.md
Name: sd_emmc_sdma_engine

Overview:
- Parametrised SDMA sequencer for the eMMC host controller.
- Replaces the boundary-only tracker.
- Walks system memory one block at a time from a start address and issues one memory request per block.
- Detects SDMA buffer-boundary crossings (4 KB..512 KB), raises a DMA interrupt and pauses until host software writes a new system address, then resumes until the block count reaches zero.

Parameters:
- ADDR_W, 32, system address width
- BLKCNT_W, 16, block count width
- BLKSIZE_W, 12, block size width in bytes (max 2048)
- BND_BASE_LOG2, 12, log2 of smallest boundary (4 KB)

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begin transfer
- abort  in  1  one-cycle pulse; cancel transfer
- init_sys_addr  in  ADDR_W  start address, sampled on start
- buf_boundary  in  3  boundary code; sampled on start only
- block_size  in  BLKSIZE_W  bytes per block; sampled on start; 0 is illegal
- block_count  in  BLKCNT_W  blocks to move; sampled on start
- sys_addr_wr  in  1  one-cycle pulse; host rewrote system address register
- sys_addr_in  in  ADDR_W  new address accompanying sys_addr_wr
- mem_req  out  1  request valid
- mem_ack  in  1  request accepted; handshake completes when mem_req && mem_ack
- mem_addr  out  ADDR_W  block start address
- mem_len  out  BLKSIZE_W  block length
- blk_done  in  1  one-cycle pulse; current block fully moved
- busy  out  1  transfer in progress
- dma_int  out  1  one-cycle pulse; boundary reached
- xfer_complete  out  1  one-cycle pulse; all blocks done
- cur_sys_addr  out  ADDR_W  next address, for register readback
- blocks_left  out  BLKCNT_W  remaining blocks

Behaviour:
- Reset values: all outputs 0; state IDLE; internal registers 0.
- Boundary size = 2^(BND_BASE_LOG2 + buf_boundary) bytes. A crossing occurs when (old_addr >> shift) != (new_addr >> shift). Address wrap-around counts as a crossing.
- IDLE:
  - start with block_count != 0: latch init_sys_addr, block_size, block_count and shift, then go to REQ; busy=1 from the next cycle.
  - start with block_count == 0: xfer_complete pulses next cycle; stay in IDLE.
- REQ:
  - mem_req=1, mem_addr=cur_sys_addr, mem_len=latched size.
  - On mem_ack, go to XFER; mem_req drops the next cycle.
- XFER:
  - On blk_done: cur_sys_addr += size (mod 2^ADDR_W); blocks_left -= 1; go to CHECK.
  - blk_done in any other state is ignored.
- CHECK (one cycle), in priority order:
  - blocks_left == 0: xfer_complete pulse, go to IDLE, busy=0. A crossing on the final block raises no dma_int.
  - Crossing: dma_int pulse, go to WAIT_ADDR.
  - Otherwise: go to REQ.
- WAIT_ADDR:
  - sys_addr_wr loads cur_sys_addr=sys_addr_in and goes to REQ.
  - No timeout.
- sys_addr_wr outside WAIT_ADDR is ignored.
- start while busy is ignored.
- abort in any state: next cycle IDLE, busy=0, mem_req=0, no xfer_complete and no dma_int. abort beats a simultaneous blk_done, mem_ack or sys_addr_wr.
- reset mid-transfer: same as abort, plus all registers cleared.
- Latency: start to mem_req = 1 cycle; blk_done to next mem_req = 2 cycles when no boundary is crossed.

Optional Feature:
- Macro: SD_EMMC_SDMA_BLK_GAP_EN
- Enabled:
  - Adds input stop_at_gap and input continue_req, and output gap_stopped.
  - In CHECK, if stop_at_gap=1 and blocks remain, enter state GAP (gap_stopped=1) instead of REQ or WAIT_ADDR.
  - A boundary dma_int still pulses first and is remembered.
  - continue_req leaves GAP: to WAIT_ADDR if a crossing is pending, else to REQ.
  - abort from GAP behaves as abort elsewhere.
- Disabled: the ports and the GAP state do not exist.

Decomposition:
- Package sd_emmc_sdma_pkg:
  - state encoding (IDLE, REQ, XFER, CHECK, WAIT_ADDR, GAP)
  - BND_BASE_LOG2 default
  - boundary-shift function
- Sub-module sd_emmc_sdma_bnd_chk: combinational old/new address + shift -> crossing flag. This makes the crossing check unit-testable on its own.

Test Plan:
- addr 0x0000_0000, bnd 0 (4 KB), size 512, count 16, host writes 0x0010_0000 after the dma_int:
  - dma_int after block 8 with cur_sys_addr=0x1000
  - 8 more blocks complete, xfer_complete, final cur_sys_addr=0x0010_1000
  - no second dma_int
- Unaligned addr 0x0000_0F00, bnd 0, size 512, count 2: dma_int after block 1 with cur_sys_addr=0x1100.
- addr 0, bnd 7 (512 KB), size 512, count 1024: 1024 requests, xfer_complete, zero dma_int pulses.
- start with count 0: no mem_req, xfer_complete pulses 1 cycle after start, busy stays 0.
- abort in the same cycle as blk_done on block 3 of 8: busy=0 next cycle, no xfer_complete; a later start works normally.
- SD_EMMC_SDMA_BLK_GAP_EN, stop_at_gap=1, count 3:
  - gap_stopped after each of blocks 1 and 2
  - each continue_req resumes REQ within 1 cycle
  - xfer_complete after block 3
